// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler.
// Holds the update record layout and small helpers.
package bp_pkg;

   localparam int BP_SIZE   = 32;
   localparam int BP_ENTRIES = 32;
   localparam int BP_IDX_W  = $clog2(BP_ENTRIES);
   localparam int BP_HIST_W = BP_IDX_W + 1;

   typedef struct packed {
      logic [BP_SIZE-1:0]   pc;
      logic                 mispred;
      logic [BP_HIST_W-1:0] ghist;
      logic [BP_SIZE-1:0]   correct_pc;
      logic                 is_jalr;
   } bp_update_t;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Update bus between resolve stage, scheduler and predictor tables.
// master = producer/consumer side, slave = the scheduler.
interface bp_update_scheduler_if #(
   parameter int size        = 32,
   parameter int INDEX_WIDTH = 5,
   parameter int DEPTH       = 8
);
   logic                   upd_valid_i_0, upd_valid_i_1, upd_valid_i_2;
   logic [size-1:0]        upd_pc_i_0, upd_pc_i_1, upd_pc_i_2;
   logic                   upd_mispred_i_0, upd_mispred_i_1, upd_mispred_i_2;
   logic [INDEX_WIDTH:0]   upd_ghist_i_0, upd_ghist_i_1, upd_ghist_i_2;
   logic [size-1:0]        upd_correct_pc_i_0, upd_correct_pc_i_1;
   logic [size-1:0]        upd_correct_pc_i_2;
   logic                   upd_is_jalr_i_0, upd_is_jalr_i_1, upd_is_jalr_i_2;
   logic                   in_ready_o;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [size-1:0]        out_pc_o;
   logic                   out_mispred_o;
   logic [INDEX_WIDTH:0]   out_ghist_o;
   logic [size-1:0]        out_correct_pc_o;
   logic                   out_is_jalr_o;
   logic [$clog2(DEPTH):0] occupancy_o;
   logic [7:0]             drop_count_o;

   modport master (
      output upd_valid_i_0, upd_valid_i_1, upd_valid_i_2,
      output upd_pc_i_0, upd_pc_i_1, upd_pc_i_2,
      output upd_mispred_i_0, upd_mispred_i_1, upd_mispred_i_2,
      output upd_ghist_i_0, upd_ghist_i_1, upd_ghist_i_2,
      output upd_correct_pc_i_0, upd_correct_pc_i_1, upd_correct_pc_i_2,
      output upd_is_jalr_i_0, upd_is_jalr_i_1, upd_is_jalr_i_2,
      output out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_mispred_o,
      input  out_ghist_o, out_correct_pc_o, out_is_jalr_o,
      input  occupancy_o, drop_count_o
   );

   modport slave (
      input  upd_valid_i_0, upd_valid_i_1, upd_valid_i_2,
      input  upd_pc_i_0, upd_pc_i_1, upd_pc_i_2,
      input  upd_mispred_i_0, upd_mispred_i_1, upd_mispred_i_2,
      input  upd_ghist_i_0, upd_ghist_i_1, upd_ghist_i_2,
      input  upd_correct_pc_i_0, upd_correct_pc_i_1, upd_correct_pc_i_2,
      input  upd_is_jalr_i_0, upd_is_jalr_i_1, upd_is_jalr_i_2,
      input  out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_mispred_o,
      output out_ghist_o, out_correct_pc_o, out_is_jalr_o,
      output occupancy_o, drop_count_o
   );
endinterface

// File: rtl/bp_update_fifo_mw.sv
// Circular buffer of predictor updates: up to three writes,
// one read per cycle. Owns the pointers and the entry count.
module bp_update_fifo_mw
   import bp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             wr_num,
   input  bp_update_t             wr_data [3],
   input  logic                   rd_en,
   output bp_update_t             rd_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   bp_update_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // write the first wr_num compacted slots from wr_ptr onward
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (k < int'(wr_num)) mem[wr_ptr + AW'(k)] <= wr_data[k];
         end
      end
   end

   // pointers wrap at DEPTH; count tracks enqueues minus dequeues
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_num);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count  <= count + CW'(wr_num) - CW'(rd_en);
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/bp_update_scheduler.sv
// Merges up to three resolved predictor updates per cycle into
// one in-order stream toward the gshare/JALR tables.
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int size        = 32,
   parameter int ENTRIES     = 32,
   parameter int INDEX_WIDTH = $clog2(ENTRIES),
   parameter int DEPTH       = 8
) (
   input logic                  clk,
   input logic                  reset,
   bp_update_scheduler_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   if (size != BP_SIZE || INDEX_WIDTH != BP_IDX_W) begin : g_w_chk
      $error("bp_update_scheduler: widths differ from bp_pkg");
   end
   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_d_chk
      $error("bp_update_scheduler: DEPTH must be a power of two >= 4");
   end

   bp_update_t    req  [3];
   bp_update_t    slot [3];
   bp_update_t    head;
   logic [2:0]    v;
   logic [1:0]    n_req;
   logic [1:0]    wr_num;
   logic          in_ready;
   logic          rd_en;
   logic [CW-1:0] count;
   logic [7:0]    drop_count;
   logic [8:0]    drop_sum;

   assign v = {bus.upd_valid_i_2, bus.upd_valid_i_1, bus.upd_valid_i_0};

   assign req[0] = {bus.upd_pc_i_0, bus.upd_mispred_i_0,
                    bus.upd_ghist_i_0, bus.upd_correct_pc_i_0,
                    bus.upd_is_jalr_i_0};
   assign req[1] = {bus.upd_pc_i_1, bus.upd_mispred_i_1,
                    bus.upd_ghist_i_1, bus.upd_correct_pc_i_1,
                    bus.upd_is_jalr_i_1};
   assign req[2] = {bus.upd_pc_i_2, bus.upd_mispred_i_2,
                    bus.upd_ghist_i_2, bus.upd_correct_pc_i_2,
                    bus.upd_is_jalr_i_2};

   // squeeze out invalid requests, keeping FU0 < FU1 < FU2 order
   assign slot[0] = v[0] ? req[0] : (v[1] ? req[1] : req[2]);
   assign slot[1] = (v[0] & v[1]) ? req[1] : req[2];
   assign slot[2] = req[2];

   // ready looks only at registered count, never at this cycle's dequeue
   assign in_ready = (count <= CW'(DEPTH - 3));
   assign n_req    = popcount3(v);
   assign wr_num   = in_ready ? n_req : 2'd0;
   assign rd_en    = bus.out_ready_i & (count != '0);
   assign drop_sum = {1'b0, drop_count} + 9'(n_req);

   // count requests offered while not ready, saturating at 255
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (!in_ready) begin
         drop_count <= drop_sum[8] ? 8'hff : drop_sum[7:0];
      end
   end

   bp_update_fifo_mw #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_num  (wr_num),
      .wr_data (slot),
      .rd_en   (rd_en),
      .rd_data (head),
      .count   (count)
   );

   assign bus.in_ready_o       = in_ready;
   assign bus.out_valid_o      = (count != '0);
   assign bus.out_pc_o         = head.pc;
   assign bus.out_mispred_o    = head.mispred;
   assign bus.out_ghist_o      = head.ghist;
   assign bus.out_correct_pc_o = head.correct_pc;
   assign bus.out_is_jalr_o    = head.is_jalr;
   assign bus.occupancy_o      = count;
   assign bus.drop_count_o     = drop_count;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed steps then random
// traffic, checked against a queue-based reference.
module tb_bp_update_scheduler;

   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] pc;
      logic        mis;
      logic [5:0]  gh;
      logic [31:0] cpc;
      logic        jalr;
   } upd_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic        fu_v    [3];
   logic [31:0] fu_pc   [3];
   logic        fu_mis  [3];
   logic [5:0]  fu_gh   [3];
   logic [31:0] fu_cpc  [3];
   logic        fu_jalr [3];
   logic        rdy = 1'b0;

   upd_t q[$];
   int   drops = 0;
   int   tests = 0;
   int   fails = 0;

   bp_update_scheduler_if #(.size(32), .INDEX_WIDTH(5), .DEPTH(DEPTH)) bus ();

   assign bus.upd_valid_i_0      = fu_v[0];
   assign bus.upd_valid_i_1      = fu_v[1];
   assign bus.upd_valid_i_2      = fu_v[2];
   assign bus.upd_pc_i_0         = fu_pc[0];
   assign bus.upd_pc_i_1         = fu_pc[1];
   assign bus.upd_pc_i_2         = fu_pc[2];
   assign bus.upd_mispred_i_0    = fu_mis[0];
   assign bus.upd_mispred_i_1    = fu_mis[1];
   assign bus.upd_mispred_i_2    = fu_mis[2];
   assign bus.upd_ghist_i_0      = fu_gh[0];
   assign bus.upd_ghist_i_1      = fu_gh[1];
   assign bus.upd_ghist_i_2      = fu_gh[2];
   assign bus.upd_correct_pc_i_0 = fu_cpc[0];
   assign bus.upd_correct_pc_i_1 = fu_cpc[1];
   assign bus.upd_correct_pc_i_2 = fu_cpc[2];
   assign bus.upd_is_jalr_i_0    = fu_jalr[0];
   assign bus.upd_is_jalr_i_1    = fu_jalr[1];
   assign bus.upd_is_jalr_i_2    = fu_jalr[2];
   assign bus.out_ready_i        = rdy;

   bp_update_scheduler #(
      .size(32), .ENTRIES(32), .INDEX_WIDTH(5), .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 3; k++) fu_v[k] = 1'b0;
   endtask

   task automatic drive(int k, logic [31:0] pc, logic mis = 1'b0,
                        logic [5:0] gh = 6'h0, logic [31:0] cpc = 32'h0,
                        logic jalr = 1'b0);
      fu_v[k]    = 1'b1;
      fu_pc[k]   = pc;
      fu_mis[k]  = mis;
      fu_gh[k]   = gh;
      fu_cpc[k]  = cpc;
      fu_jalr[k] = jalr;
   endtask

   task automatic drive_rand(int k);
      drive(k, $urandom, 1'($urandom), 6'($urandom_range(0, 63)),
            $urandom, 1'($urandom));
   endtask

   // reference: capacity-limited FIFO, ready judged before the edge
   task automatic model_step();
      bit can;
      upd_t u;
      if (reset) begin
         q.delete();
         drops = 0;
         return;
      end
      can = (DEPTH - q.size()) >= 3;
      if (rdy && q.size() != 0) void'(q.pop_front());
      for (int k = 0; k < 3; k++) begin
         if (fu_v[k]) begin
            if (can) begin
               u.pc = fu_pc[k]; u.mis = fu_mis[k]; u.gh = fu_gh[k];
               u.cpc = fu_cpc[k]; u.jalr = fu_jalr[k];
               q.push_back(u);
            end else begin
               drops++;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("occupancy", 64'(bus.occupancy_o), 64'(q.size()));
      chk("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready_o), 64'((DEPTH - q.size()) >= 3));
      chk("drop_count", 64'(bus.drop_count_o),
          64'(drops > 255 ? 255 : drops));
      if (q.size() != 0) begin
         chk("head_pc", 64'(bus.out_pc_o), 64'(q[0].pc));
         chk("head_mispred", 64'(bus.out_mispred_o), 64'(q[0].mis));
         chk("head_ghist", 64'(bus.out_ghist_o), 64'(q[0].gh));
         chk("head_cpc", 64'(bus.out_correct_pc_o), 64'(q[0].cpc));
         chk("head_jalr", 64'(bus.out_is_jalr_o), 64'(q[0].jalr));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         fu_v[k] = 1'b0; fu_pc[k] = '0; fu_mis[k] = 1'b0;
         fu_gh[k] = '0; fu_cpc[k] = '0; fu_jalr[k] = 1'b0;
      end

      // reset state
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_out_pc", 64'(bus.out_pc_o), 64'h0);
      chk("rst_out_ghist", 64'(bus.out_ghist_o), 64'h0);
      chk("rst_out_cpc", 64'(bus.out_correct_pc_o), 64'h0);

      // single update, then one-cycle ready pulse
      drive(0, 32'h100, 1'b1, 6'h15, 32'h180, 1'b0);
      cycle();
      idle();
      chk("t1_pc", 64'(bus.out_pc_o), 64'h100);
      chk("t1_ghist", 64'(bus.out_ghist_o), 64'h15);
      chk("t1_occ", 64'(bus.occupancy_o), 64'd1);
      rdy = 1'b1;
      cycle();
      rdy = 1'b0;
      chk("t1_empty", 64'(bus.out_valid_o), 64'd0);

      // FU0 + FU2 in one cycle, gap compressed
      rdy = 1'b1;
      drive(0, 32'h200);
      drive(2, 32'h208, 1'b0, 6'h2, 32'h0, 1'b1);
      cycle();
      idle();
      chk("t2_occ2", 64'(bus.occupancy_o), 64'd2);
      chk("t2_pc0", 64'(bus.out_pc_o), 64'h200);
      cycle();
      chk("t2_occ1", 64'(bus.occupancy_o), 64'd1);
      chk("t2_pc1", 64'(bus.out_pc_o), 64'h208);
      cycle();
      chk("t2_occ0", 64'(bus.occupancy_o), 64'd0);

      // fill to 6, then a triple offered while not ready
      rdy = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) drive(k, 32'h300 + 32'(r * 12 + k * 4));
         cycle();
      end
      chk("t3_occ6", 64'(bus.occupancy_o), 64'd6);
      chk("t3_notready", 64'(bus.in_ready_o), 64'd0);
      for (int k = 0; k < 3; k++) drive(k, 32'hdead0 + 32'(k));
      cycle();
      idle();
      chk("t3_drop3", 64'(bus.drop_count_o), 64'd3);
      chk("t3_occ_hold", 64'(bus.occupancy_o), 64'd6);
      rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("t3_order", 64'(bus.out_pc_o), 64'(32'h300 + 32'(i * 4)));
         cycle();
      end
      chk("t3_drained", 64'(bus.out_valid_o), 64'd0);

      // steady one-in one-out across pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(i % 3, 32'h1000 + 32'(i * 4), 1'b0, 6'(i));
         cycle();
         idle();
         chk("t4_occ", 64'(bus.occupancy_o), 64'd1);
         chk("t4_pc", 64'(bus.out_pc_o), 64'(32'h1000 + 32'(i * 4)));
      end
      cycle();

      // stall with two entries held
      rdy = 1'b0;
      drive_rand(0);
      drive_rand(1);
      cycle();
      idle();
      for (int i = 0; i < 5; i++) cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 9) < 4) drive_rand(k);
         rdy = ($urandom_range(0, 9) < 6);
         cycle();
      end
      idle();

      // drop counter saturation
      rdy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         for (int k = 0; k < 3; k++) drive_rand(k);
         cycle();
      end
      idle();
      chk("sat_255", 64'(bus.drop_count_o), 64'd255);

      // reset with 5 held and inputs active
      rdy = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) drive_rand(k);
      cycle();
      drive_rand(0);
      drive_rand(1);
      fu_v[2] = 1'b0;
      cycle();
      chk("t6_occ5", 64'(bus.occupancy_o), 64'd5);
      for (int k = 0; k < 3; k++) drive_rand(k);
      rdy = 1'b1;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      idle();
      rdy = 1'b0;
      chk("t6_occ0", 64'(bus.occupancy_o), 64'd0);
      chk("t6_valid0", 64'(bus.out_valid_o), 64'd0);
      chk("t6_drop0", 64'(bus.drop_count_o), 64'd0);
      chk("t6_ready1", 64'(bus.in_ready_o), 64'd1);
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
